// File: rtl/rotation_aligner.sv
// rotation_aligner
//   Receive-side inverse of a barrel rotator. The input words were right-rotated
//   by an unknown fixed amount and framed with SYNC_PATTERN every FRAME_LEN words.
//   The block tries each rotation amount in turn. When a sync match appears, it
//   verifies that match over further frames and then locks. While locked it
//   outputs the payload words, left-rotated by the amount it found.
//
// Parameters
//   SYNC_PATTERN  sync word; it must differ from all 7 of its non-trivial rotations
//   FRAME_LEN     words per frame, word 0 is the sync word (legal range 2..16)
//   LOCK_COUNT    consecutive good syncs, first match included, needed to lock
//   LOSS_COUNT    consecutive missed syncs while locked that drop the lock
//
// Ports
//   clk           rising-edge clock
//   reset         asynchronous active-high reset
//   in_valid      data_in carries a word this cycle
//   data_in       rotated input word
//   data_out      de-rotated payload word (registered)
//   out_valid     data_out is valid for one cycle (payload words, locked only)
//   locked        high while in LOCKED
//   amount        current candidate or locked left-rotation amount
//   sync_err_cnt  saturating count of missed syncs while locked. Present only
//                 when ROTATION_ALIGNER_ERRCNT_EN is defined.
module rotation_aligner #(
  parameter logic [7:0]  SYNC_PATTERN = 8'hB8,
  parameter int unsigned FRAME_LEN    = 4,
  parameter int unsigned LOCK_COUNT   = 3,
  parameter int unsigned LOSS_COUNT   = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       in_valid,
  input  logic [7:0] data_in,
  output logic [7:0] data_out,
  output logic       out_valid,
  output logic       locked,
  output logic [2:0] amount
`ifdef ROTATION_ALIGNER_ERRCNT_EN
  ,
  output logic [7:0] sync_err_cnt
`endif
);

  typedef enum logic [1:0] {
    SEARCH,
    VERIFY,
    LOCKED
  } state_t;

  localparam logic [3:0] LAST_IDX = 4'(FRAME_LEN - 1);
  localparam logic [7:0] LOCK_TGT = 8'(LOCK_COUNT);
  localparam logic [7:0] LOSS_TGT = 8'(LOSS_COUNT);

  state_t      state;
  logic [3:0]  win_cnt;
  logic [3:0]  pos;
  logic [7:0]  good;
  logic [7:0]  miss;

  logic [15:0] dbl;
  logic [7:0]  corr;
  logic        match;
  logic [3:0]  pos_next;

  // The upper byte of the doubled word, shifted left, is the left rotation.
  always_comb begin
    dbl      = {data_in, data_in} << amount;
    corr     = dbl[15:8];
    match    = (corr == SYNC_PATTERN);
    pos_next = (pos == LAST_IDX) ? '0 : pos + 4'd1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= SEARCH;
      win_cnt   <= '0;
      pos       <= '0;
      good      <= '0;
      miss      <= '0;
      amount    <= '0;
      data_out  <= '0;
      out_valid <= 1'b0;
      locked    <= 1'b0;
`ifdef ROTATION_ALIGNER_ERRCNT_EN
      sync_err_cnt <= '0;
`endif
    end else begin
      out_valid <= 1'b0;
      if (in_valid) begin
        unique case (state)
          SEARCH: begin
            if (match) begin
              pos <= 4'd1;
              if (LOCK_COUNT == 1) begin
                state  <= LOCKED;
                locked <= 1'b1;
                miss   <= '0;
`ifdef ROTATION_ALIGNER_ERRCNT_EN
                sync_err_cnt <= '0;
`endif
              end else begin
                state <= VERIFY;
                good  <= 8'd1;
              end
            end else if (win_cnt == LAST_IDX) begin
              amount  <= amount + 3'd1;
              win_cnt <= '0;
            end else begin
              win_cnt <= win_cnt + 4'd1;
            end
          end

          VERIFY: begin
            pos <= pos_next;
            if (pos == '0) begin
              if (match) begin
                if (good + 8'd1 == LOCK_TGT) begin
                  state  <= LOCKED;
                  locked <= 1'b1;
                  miss   <= '0;
`ifdef ROTATION_ALIGNER_ERRCNT_EN
                  sync_err_cnt <= '0;
`endif
                end else begin
                  good <= good + 8'd1;
                end
              end else begin
                // A match that does not repeat was a payload word. Move on
                // to the next amount so the search cannot settle on it again.
                state   <= SEARCH;
                amount  <= amount + 3'd1;
                win_cnt <= '0;
              end
            end
          end

          LOCKED: begin
            pos <= pos_next;
            if (pos != '0) begin
              data_out  <= corr;
              out_valid <= 1'b1;
            end else if (match) begin
              miss <= '0;
            end else begin
`ifdef ROTATION_ALIGNER_ERRCNT_EN
              if (sync_err_cnt != 8'hFF) sync_err_cnt <= sync_err_cnt + 8'd1;
`endif
              if (miss + 8'd1 == LOSS_TGT) begin
                state   <= SEARCH;
                locked  <= 1'b0;
                win_cnt <= '0;
                miss    <= '0;
              end else begin
                miss <= miss + 8'd1;
              end
            end
          end

          default: state <= SEARCH;
        endcase
      end
    end
  end

endmodule
